// File: rtl/user_timer.sv
// user_timer: memory-mapped compare timer behind the user OBI demux.
// Counts prescaled clock ticks, flags COUNT == COMPARE in STATUS.PENDING and
// drives a level interrupt (PENDING & IRQ_EN).
// Optional feature macro: USER_TIMER_PRESCALER_EN (defined -> programmable
// 8-bit prescaler in CTRL[15:8]; undefined -> tick on every enabled cycle).

package user_timer_pkg;

  typedef struct packed {
    int unsigned DataWidth;
    int unsigned AddrWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t SbrObiCfg = '{DataWidth: 32, AddrWidth: 32, IdWidth: 4};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    sbr_obi_a_chan_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

endpackage

module user_timer
  import user_timer_pkg::*;
#(
  parameter obi_cfg_t ObiCfg    = SbrObiCfg,
  parameter type      obi_req_t = sbr_obi_req_t,
  parameter type      obi_rsp_t = sbr_obi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output logic     irq_o
);

  localparam int unsigned IdW = ObiCfg.IdWidth;

  localparam logic [2:0] IdxCtrl    = 3'd0;
  localparam logic [2:0] IdxCount   = 3'd1;
  localparam logic [2:0] IdxCompare = 3'd2;
  localparam logic [2:0] IdxStatus  = 3'd3;

  // Request unpacking
  logic           w_req;
  logic           w_we;
  logic [2:0]     w_idx;
  logic [3:0]     w_be;
  logic [31:0]    w_wdata;
  logic [IdW-1:0] w_aid;
  logic           w_unused_addr;

  assign w_req         = obi_req_i.req;
  assign w_we          = obi_req_i.a.we;
  assign w_idx         = obi_req_i.a.addr[4:2];
  assign w_be          = obi_req_i.a.be;
  assign w_wdata       = obi_req_i.a.wdata;
  assign w_aid         = obi_req_i.a.aid;
  assign w_unused_addr = ^{obi_req_i.a.addr[31:5], obi_req_i.a.addr[1:0]};

  // Offsets 0x10..0x1C have no register behind them
  logic w_unmapped;
  logic w_wr;
  logic w_wr_ctrl;
  logic w_wr_count;
  logic w_wr_compare;
  logic w_wr_status;

  assign w_unmapped   = w_idx[2];
  assign w_wr         = w_req & w_we;
  assign w_wr_ctrl    = w_wr & (w_idx == IdxCtrl);
  assign w_wr_count   = w_wr & (w_idx == IdxCount);
  assign w_wr_compare = w_wr & (w_idx == IdxCompare);
  assign w_wr_status  = w_wr & (w_idx == IdxStatus);

  // Byte-lane mask for the full-width registers
  logic [31:0] w_byte_mask;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gen_byte_mask
      assign w_byte_mask[gi*8 +: 8] = {8{w_be[gi]}};
    end
  endgenerate

  // Architectural state
  logic        r_en;
  logic        r_autoreload;
  logic        r_irq_en;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_pending;

  logic        w_tick;
  logic [7:0]  w_presc_rd;

`ifdef USER_TIMER_PRESCALER_EN
  logic [7:0] r_presc;
  logic [7:0] r_presc_cnt;

  assign w_tick     = r_en & (r_presc_cnt == r_presc);
  assign w_presc_rd = r_presc;

  // Prescaler divider: wraps on tick, held at 0 while the timer is disabled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_presc_cnt <= 8'd0;
    end else if (!r_en || w_tick) begin
      r_presc_cnt <= 8'd0;
    end else begin
      r_presc_cnt <= r_presc_cnt + 8'd1;
    end
  end

  // PRESC field of CTRL, byte lane 1
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_presc <= 8'd0;
    end else if (w_wr_ctrl && w_be[1]) begin
      r_presc <= w_wdata[15:8];
    end
  end
`else
  assign w_tick     = r_en;
  assign w_presc_rd = 8'd0;
`endif

  // CTRL control bits, byte lane 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_en         <= 1'b0;
      r_autoreload <= 1'b0;
      r_irq_en     <= 1'b0;
    end else if (w_wr_ctrl && w_be[0]) begin
      r_en         <= w_wdata[0];
      r_autoreload <= w_wdata[1];
      r_irq_en     <= w_wdata[2];
    end
  end

  // COMPARE register with per-lane write; new value is used from the next tick
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_compare <= 32'd0;
    end else if (w_wr_compare) begin
      r_compare <= (r_compare & ~w_byte_mask) | (w_wdata & w_byte_mask);
    end
  end

  logic w_match;
  logic w_count_sw_wr;
  logic w_w1c;

  assign w_match       = (r_count == r_compare);
  assign w_count_sw_wr = w_wr_count & (|w_be);
  assign w_w1c         = w_wr_status & w_be[0] & w_wdata[0];

  // Counter and PENDING: software COUNT write beats the tick, but the match is
  // still judged on the old COUNT; a new match beats a W1C of PENDING.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count   <= 32'd0;
      r_pending <= 1'b0;
    end else begin
      if (w_count_sw_wr) begin
        r_count <= (r_count & ~w_byte_mask) | (w_wdata & w_byte_mask);
      end else if (w_tick) begin
        r_count <= (w_match && r_autoreload) ? 32'd0 : r_count + 32'd1;
      end

      if (w_tick && w_match) begin
        r_pending <= 1'b1;
      end else if (w_w1c) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Read data mux; unmapped offsets read as zero
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = 32'd0;
    case (w_idx)
      IdxCtrl:    w_rdata = {16'd0, w_presc_rd, 5'd0, r_irq_en, r_autoreload, r_en};
      IdxCount:   w_rdata = r_count;
      IdxCompare: w_rdata = r_compare;
      IdxStatus:  w_rdata = {31'd0, r_pending};
      default:    w_rdata = 32'd0;
    endcase
  end

  logic           r_rvalid;
  logic [31:0]    r_rdata;
  logic [IdW-1:0] r_rid;
  logic           r_err;

  // Response stage: exactly one cycle after grant, dropped by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
      r_rid    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_req;
      r_rdata  <= (w_req && !w_we) ? w_rdata : 32'd0;
      r_err    <= w_req & w_unmapped;
      if (w_req) begin
        r_rid <= w_aid;
      end
    end
  end

  // Response assembly; every request is granted in its own cycle
  always_comb begin
    obi_rsp_o          = '0;
    obi_rsp_o.gnt      = w_req;
    obi_rsp_o.rvalid   = r_rvalid;
    obi_rsp_o.r.rdata  = r_rdata;
    obi_rsp_o.r.rid    = r_rid;
    obi_rsp_o.r.err    = r_err;
  end

  assign irq_o = r_pending & r_irq_en;

endmodule

// File: doc/user_timer.md
# user_timer

Memory-mapped compare timer that sits behind the user-domain OBI subordinate demux as a new user subordinate. It takes requests from one demux manager port and returns responses on it. It counts prescaled clock ticks, flags a match against a programmable compare value, and drives one level interrupt into the user interrupt vector (`interrupts_o[3]`).

## Interface
- `ObiCfg`, default `SbrObiCfg`: OBI configuration; DataWidth must be 32.
- `obi_req_t`, default `sbr_obi_req_t`: subordinate request struct.
- `obi_rsp_t`, default `sbr_obi_rsp_t`: subordinate response struct.
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset; synchronous and active-high.
- `obi_req_i`  in  `obi_req_t`  OBI request: `req`, `a.addr`, `a.we`, `a.be`, `a.wdata`, `a.aid`.
- `obi_rsp_o`  out  `obi_rsp_t`  OBI response: `gnt`, `rvalid`, `r.rdata`, `r.rid`, `r.err`.
- `irq_o`  out  1  level interrupt, equal to `PENDING & IRQ_EN`.

## Operation
- Register map, decoded from `addr[4:2]`; all registers 32 bit:
  - 0x00 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN, bits[15:8] PRESC. All other bits read 0.
  - 0x04 COUNT: read/write.
  - 0x08 COMPARE: read/write.
  - 0x0C STATUS: bit0 PENDING; writing 1 clears it, writing 0 has no effect.
  - 0x10 to 0x1C: unmapped. Reads return 0, writes are dropped, `err`=1.
- Writes honour `be` per byte lane. Reads ignore `be`.
- Prescaler:
  - An 8-bit `presc_cnt` advances only while EN=1.
  - `tick` = EN & (`presc_cnt` == PRESC). On `tick`, `presc_cnt` returns to 0; otherwise it increments.
  - With PRESC=0, `tick` fires every cycle.
  - Clearing EN resets `presc_cnt` to 0.
- Counter, updated on `tick` only:
  - If COUNT == COMPARE: set PENDING. COUNT becomes 0 if AUTORELOAD=1, otherwise COUNT+1.
  - Otherwise COUNT becomes COUNT+1.
  - Arithmetic is modulo 2^32; 0xFFFFFFFF wraps to 0 and does not set PENDING unless it matches COMPARE.
- Simultaneous events:
  - A software write to COUNT in the same cycle as `tick` wins; the tick is lost for COUNT, but a match is still evaluated on the old COUNT.
  - A STATUS W1C in the same cycle as a new match: set wins, PENDING stays 1.
  - A COMPARE write takes effect for the next `tick`.

## Timing
- Reset values: all registers 0, `presc_cnt` 0, `irq_o`=0, `gnt`=0, `rvalid`=0, `rdata`=0, `rid`=0, `err`=0.
- `gnt` = `req` combinationally; every request is accepted in its request cycle.
- The response follows exactly one cycle after grant:
  - `rvalid`=1 for one cycle.
  - `rid` = registered `aid`.
  - `rdata` = register value sampled in the grant cycle, or 0 for writes.
  - `err` as defined by the register map.
- Back-to-back requests produce back-to-back `rvalid` cycles. There is no backpressure on `rvalid`.
- Register write side effects are visible in the cycle after grant. A read in the cycle after a write returns the new value.
- `irq_o` is driven combinationally from registers: it rises in the cycle after the matching `tick` and falls in the cycle after the W1C or the IRQ_EN clear.
- Reset asserted mid-transaction: the pending `rvalid` is dropped, and all state returns to reset values on the next edge.

## Configuration
- `USER_TIMER_PRESCALER_EN`:
  - Defined: PRESC is writable and operates as described above.
  - Undefined: `presc_cnt` is removed, CTRL[15:8] reads 0 and ignores writes, and `tick` = EN every cycle.

## Test plan
- Reset, then read all five offsets: 0x00/04/08/0C return 0 with `err`=0; 0x10 returns 0 with `err`=1; `rid` echoes `aid`.
- COMPARE=5, CTRL=0x7 (PRESC=0): `irq_o` rises exactly 6 cycles after the CTRL write's response cycle, and COUNT reads 0 afterwards (autoreload). W1C STATUS=1 drops `irq_o` the next cycle.
- PRESC=3, COMPARE=2, AUTORELOAD=0: COUNT increments every 4 cycles, PENDING sets on the third tick, and COUNT continues 3, 4, ...
- COUNT=0xFFFFFFFF, COMPARE=0x10, EN=1: COUNT wraps to 0 with no PENDING. A write with `be`=0x1 and `wdata`=0xAABBCCDD to COMPARE reads back 0x000000DD.
- Force a W1C on the same cycle as a match: PENDING stays 1. Force a COUNT write of 0x100 on a `tick` cycle: the next read returns 0x100.
- Build without `USER_TIMER_PRESCALER_EN`: a CTRL write of 0xFF07 reads back 0x7, and COUNT advances every cycle.
